// File: rtl/seven_seg_scan_monitor.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_monitor: rebuilds the 4-digit value from a scanned 7-seg bus.
// Option macro SEG_MONITOR_CONFIRM_EN: accept only two identical good frames.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seven_seg_scan_monitor #(
  parameter int MAX_DWELL = 4
) (
  input  logic        clock_1KHz,
  input  logic        reset,
  input  logic [6:0]  display,
  input  logic [2:0]  digitSelect,
  output logic [13:0] value,
  output logic [15:0] bcd,
  output logic        valueValid,
  output logic        frameError,
  output logic        locked
);

  typedef enum logic [1:0] {
    S_HUNT     = 2'd0,
    S_ONES     = 2'd1,
    S_TENS     = 2'd2,
    S_HUNDREDS = 2'd3
  } state_t;

  localparam logic [2:0] c_SEL_ONES = 3'b000;
  localparam logic [2:0] c_SEL_TENS = 3'b001;
  localparam logic [2:0] c_SEL_HUND = 3'b011;
  localparam logic [2:0] c_SEL_THOU = 3'b100;
  localparam logic [3:0] c_DWELL_LAST = 4'(MAX_DWELL - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_dwell, w_dwell_next;
  logic [3:0]  r_ones, r_tens, r_hund;
  logic        r_bad, w_bad_next;
  logic        w_cap_ones, w_cap_tens, w_cap_hund;
  logic        w_err, w_frame_done, w_good, w_accept, w_illegal;
  logic [2:0]  w_cur_sel, w_next_sel;
  logic [3:0]  w_digit;
  logic        w_digit_bad;
  logic [15:0] w_new_bcd;
  logic [13:0] w_new_value;

  // Blank (00) reads as zero so leading digits may be suppressed.
  always_comb begin
    w_digit     = 4'd0;
    w_digit_bad = 1'b0;
    case (display)
      7'h3F, 7'h00: w_digit = 4'd0;
      7'h06:        w_digit = 4'd1;
      7'h5B:        w_digit = 4'd2;
      7'h4F:        w_digit = 4'd3;
      7'h66:        w_digit = 4'd4;
      7'h6D:        w_digit = 4'd5;
      7'h7D:        w_digit = 4'd6;
      7'h07:        w_digit = 4'd7;
      7'h7F:        w_digit = 4'd8;
      7'h6F:        w_digit = 4'd9;
      default:      w_digit_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_cur_sel  = c_SEL_ONES;
    w_next_sel = c_SEL_ONES;
    case (r_state)
      S_ONES:     begin w_cur_sel = c_SEL_ONES; w_next_sel = c_SEL_TENS; end
      S_TENS:     begin w_cur_sel = c_SEL_TENS; w_next_sel = c_SEL_HUND; end
      S_HUNDREDS: begin w_cur_sel = c_SEL_HUND; w_next_sel = c_SEL_THOU; end
      default:    begin w_cur_sel = c_SEL_ONES; w_next_sel = c_SEL_ONES; end
    endcase
  end

  assign w_illegal = (digitSelect == 3'b010) || (digitSelect == 3'b101) ||
                     (digitSelect == 3'b110) || (digitSelect == 3'b111);

  always_comb begin
    w_state_next = r_state;
    w_dwell_next = r_dwell;
    w_bad_next   = r_bad;
    w_cap_ones   = 1'b0;
    w_cap_tens   = 1'b0;
    w_cap_hund   = 1'b0;
    w_err        = 1'b0;
    w_frame_done = 1'b0;
    if (w_illegal) begin
      w_err        = 1'b1;
      w_state_next = S_HUNT;
      w_dwell_next = 4'd0;
    end else if (r_state == S_HUNT) begin
      if (digitSelect == c_SEL_ONES) begin
        w_cap_ones   = 1'b1;
        w_bad_next   = w_digit_bad;
        w_state_next = S_ONES;
        w_dwell_next = 4'd0;
      end
    end else if (digitSelect == w_cur_sel) begin
      if (r_dwell == c_DWELL_LAST) begin
        w_err        = 1'b1;
        w_state_next = S_HUNT;
        w_dwell_next = 4'd0;
      end else begin
        w_dwell_next = r_dwell + 4'd1;
      end
    end else if (digitSelect == w_next_sel) begin
      w_dwell_next = 4'd0;
      w_bad_next   = r_bad | w_digit_bad;
      case (r_state)
        S_ONES:  begin w_cap_tens = 1'b1; w_state_next = S_TENS; end
        S_TENS:  begin w_cap_hund = 1'b1; w_state_next = S_HUNDREDS; end
        default: begin w_frame_done = 1'b1; w_state_next = S_HUNT; end
      endcase
    end else begin
      // Out-of-order legal code; a fresh ones digit restarts capture at once.
      w_err        = 1'b1;
      w_dwell_next = 4'd0;
      if (digitSelect == c_SEL_ONES) begin
        w_cap_ones   = 1'b1;
        w_bad_next   = w_digit_bad;
        w_state_next = S_ONES;
      end else begin
        w_state_next = S_HUNT;
      end
    end
  end

  assign w_good      = w_frame_done && !(r_bad || w_digit_bad);
  assign w_new_bcd   = {w_digit, r_hund, r_tens, r_ones};
  assign w_new_value = ({10'd0, w_digit} * 14'd1000) + ({10'd0, r_hund} * 14'd100) +
                       ({10'd0, r_tens} * 14'd10) + {10'd0, r_ones};

`ifdef SEG_MONITOR_CONFIRM_EN
  logic [15:0] r_prev_bcd;
  logic        r_prev_ok;

  assign w_accept = w_good && r_prev_ok && (r_prev_bcd == w_new_bcd);

  always_ff @(posedge clock_1KHz) begin
    if (reset) begin
      r_prev_bcd <= 16'd0;
      r_prev_ok  <= 1'b0;
    end else if (w_err || (w_frame_done && !w_good)) begin
      r_prev_ok <= 1'b0;
    end else if (w_good) begin
      r_prev_bcd <= w_new_bcd;
      r_prev_ok  <= 1'b1;
    end
  end
`else
  assign w_accept = w_good;
`endif

  always_ff @(posedge clock_1KHz) begin
    if (reset) begin
      r_state    <= S_HUNT;
      r_dwell    <= 4'd0;
      r_bad      <= 1'b0;
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      r_hund     <= 4'd0;
      value      <= 14'd0;
      bcd        <= 16'd0;
      valueValid <= 1'b0;
      frameError <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_dwell    <= w_dwell_next;
      r_bad      <= w_bad_next;
      valueValid <= w_accept;
      frameError <= w_err || (w_frame_done && !w_good);
      if (w_cap_ones) r_ones <= w_digit;
      if (w_cap_tens) r_tens <= w_digit;
      if (w_cap_hund) r_hund <= w_digit;
      if (w_accept) begin
        value <= w_new_value;
        bcd   <= w_new_bcd;
      end
      if (w_err || (w_frame_done && !w_good)) locked <= 1'b0;
      else if (w_good)                        locked <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_monitor.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_monitor: scoreboard bench for seven_seg_scan_monitor.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seven_seg_scan_monitor;

  logic        clk;
  logic        rst;
  logic [6:0]  display;
  logic [2:0]  digitSelect;
  logic [13:0] value;
  logic [15:0] bcd;
  logic        valueValid;
  logic        frameError;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_err;
    logic [13:0] v;
    logic [15:0] b;
    bit          lk;
  } exp_t;

  exp_t exp_q[$];

  seven_seg_scan_monitor #(.MAX_DWELL(4)) dut (
    .clock_1KHz (clk),
    .reset      (rst),
    .display    (display),
    .digitSelect(digitSelect),
    .value      (value),
    .bcd        (bcd),
    .valueValid (valueValid),
    .frameError (frameError),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valueValid && frameError) begin
      n_tests++;
      n_fail++;
      $display("FAIL pulse_excl: valueValid=1 frameError=1, required not both");
    end else if (valueValid || frameError) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: valueValid=%0b frameError=%0b, required none", valueValid, frameError);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (frameError != e.is_err || value != e.v || bcd != e.b) begin
          n_fail++;
          $display("FAIL event: err=%0b value=%0d bcd=%h, required err=%0b value=%0d bcd=%h",
                   frameError, value, bcd, e.is_err, e.v, e.b);
        end
        n_tests++;
        if (locked != e.lk) begin
          n_fail++;
          $display("FAIL locked: got %0b, required %0b", locked, e.lk);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] sel, input logic [6:0] seg, input int n);
    repeat (n) begin
      @(negedge clk);
      digitSelect = sel;
      display     = seg;
    end
  endtask

  task automatic expect_ev(input bit is_err, input logic [13:0] v, input logic [15:0] b, input bit lk);
    exp_t e;
    e.is_err = is_err;
    e.v      = v;
    e.b      = b;
    e.lk     = lk;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    rst         = 1'b1;
    digitSelect = 3'b100;
    display     = 7'h00;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_pulses", {30'd0, valueValid, frameError}, 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    drive(3'b100, 7'h00, 2);

    // 1234, one clock per digit
    drive(3'b000, 7'h66, 1);
    drive(3'b001, 7'h4F, 1);
    drive(3'b011, 7'h5B, 1);
    drive(3'b100, 7'h06, 1);
    expect_ev(1'b0, 14'd1234, 16'h1234, 1'b1);
    drive(3'b100, 7'h00, 2);

    // invalid tens pattern: fault at thousands edge, value retained
    drive(3'b000, 7'h66, 1);
    drive(3'b001, 7'h55, 1);
    drive(3'b011, 7'h5B, 1);
    drive(3'b100, 7'h06, 1);
    expect_ev(1'b1, 14'd1234, 16'h1234, 1'b0);
    drive(3'b100, 7'h00, 1);

    // 9999 twice, two clocks per digit
    repeat (2) begin
      drive(3'b000, 7'h6F, 2);
      drive(3'b001, 7'h6F, 2);
      drive(3'b011, 7'h6F, 2);
      drive(3'b100, 7'h6F, 1);
      expect_ev(1'b0, 14'd9999, 16'h9999, 1'b1);
      drive(3'b100, 7'h6F, 1);
    end

    // restart on an early ones code, then 8765
    drive(3'b000, 7'h6D, 1);
    drive(3'b001, 7'h7D, 1);
    drive(3'b000, 7'h6D, 1);
    expect_ev(1'b1, 14'd9999, 16'h9999, 1'b0);
    drive(3'b001, 7'h7D, 1);
    drive(3'b011, 7'h07, 1);
    drive(3'b100, 7'h7F, 1);
    expect_ev(1'b0, 14'd8765, 16'h8765, 1'b1);
    drive(3'b100, 7'h00, 1);

    // illegal select code
    drive(3'b110, 7'h00, 1);
    expect_ev(1'b1, 14'd8765, 16'h8765, 1'b0);
    drive(3'b100, 7'h00, 1);

    // dwell timeout: 001 seen on five consecutive edges
    drive(3'b000, 7'h3F, 1);
    drive(3'b001, 7'h3F, 4);
    drive(3'b001, 7'h3F, 1);
    expect_ev(1'b1, 14'd8765, 16'h8765, 1'b0);
    drive(3'b100, 7'h00, 2);

    // reset mid-frame, then 0042 with blank leading digits
    drive(3'b000, 7'h66, 1);
    drive(3'b001, 7'h4F, 1);
    @(negedge clk);
    rst         = 1'b1;
    digitSelect = 3'b011;
    display     = 7'h5B;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_value", 32'(value), 32'd0);
    drive(3'b000, 7'h5B, 1);
    drive(3'b001, 7'h66, 1);
    drive(3'b011, 7'h00, 1);
    drive(3'b100, 7'h00, 1);
    expect_ev(1'b0, 14'd42, 16'h0042, 1'b1);
    drive(3'b100, 7'h00, 3);

    check("final_value", 32'(value), 32'd42);
    check("final_locked", 32'(locked), 32'd1);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
